// File: rtl/lcd_display_sysid_checker.sv
// -----------------------------------------------------------------------------
// lcd_display_sysid_checker
//
// Avalon-MM read master that checks the system-ID slave before the LCD is
// driven. A check reads the ID word at address 0 and then the timestamp word
// at address 1. It compares both against build-time constants and reports
// pass/fail/timeout.
//
// A check is started by a start pulse while idle. When AUTO_START=1, a check
// also starts on the first cycle after reset release.
//
// Ports
//   clock            : single clock for the whole block
//   reset            : asynchronous, active-high reset
//   start            : one-cycle request to run a check (ignored while busy)
//   avm_address      : word address (0 = ID, 1 = timestamp), registered
//   avm_read         : read strobe, registered
//   avm_waitrequest  : slave stall
//   avm_readdata     : read data (valid READ_LATENCY cycles after acceptance)
//   busy             : a check is in progress
//   done             : check finished; held until the next accepted start
//   id_ok            : captured ID matched EXPECTED_ID
//   timestamp_ok     : captured timestamp matched EXPECTED_TIMESTAMP
//   timeout          : the last check aborted because a read phase ran too long
//   id_value         : captured ID word
//   timestamp_value  : captured timestamp word
// -----------------------------------------------------------------------------
module lcd_display_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1430493118,
    parameter int          READ_LATENCY       = 0,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        timestamp_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] timestamp_value
);

    localparam logic [1:0]  LAT_LIM = 2'(READ_LATENCY);
    localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_ID  = 3'd1,
        LAT_ID = 3'd2,
        RD_TS  = 3'd3,
        LAT_TS = 3'd4,
        FIN    = 3'd5
    } state_t;

    state_t      state_r, state_s;
    logic        first_r, first_s;      // high only on the first cycle after reset release
    logic [15:0] tmo_r, tmo_s;          // cycles spent in the current read phase
    logic [1:0]  lat_r, lat_s;          // read-latency cycles elapsed after acceptance
    logic        read_r, read_s;
    logic        addr_r, addr_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        id_ok_r, id_ok_s;
    logic        ts_ok_r, ts_ok_s;
    logic        timeout_r, timeout_s;
    logic [31:0] id_value_r, id_value_s;
    logic [31:0] ts_value_r, ts_value_s;

    logic        capture_s;             // a data word is being captured this cycle
    logic        in_phase_s;            // FSM is in one of the RD_x / LAT_x states
    logic [15:0] tmo_inc_s;
    logic [1:0]  lat_inc_s;

    // Next-state and next-output logic; every output is registered from these values
    always_comb begin
        state_s    = state_r;
        first_s    = 1'b0;
        tmo_s      = tmo_r;
        lat_s      = lat_r;
        read_s     = read_r;
        addr_s     = addr_r;
        busy_s     = busy_r;
        done_s     = done_r;
        id_ok_s    = id_ok_r;
        ts_ok_s    = ts_ok_r;
        timeout_s  = timeout_r;
        id_value_s = id_value_r;
        ts_value_s = ts_value_r;
        capture_s  = 1'b0;
        in_phase_s = 1'b0;
        tmo_inc_s  = tmo_r + 16'd1;
        lat_inc_s  = lat_r + 2'd1;

        case (state_r)
            IDLE: begin
                // An external start arriving on the release cycle is not honoured;
                // only the automatic run may use that cycle.
                if ((first_r && AUTO_START) || (!first_r && start)) begin
                    state_s    = RD_ID;
                    read_s     = 1'b1;
                    addr_s     = 1'b0;
                    busy_s     = 1'b1;
                    done_s     = 1'b0;
                    id_ok_s    = 1'b0;
                    ts_ok_s    = 1'b0;
                    timeout_s  = 1'b0;
                    id_value_s = 32'd0;
                    ts_value_s = 32'd0;
                    tmo_s      = 16'd0;
                    lat_s      = 2'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            RD_ID: begin
                in_phase_s = 1'b1;
                if (!avm_waitrequest) begin
                    if (LAT_LIM == 2'd0) begin
                        capture_s  = 1'b1;
                        id_value_s = avm_readdata;
                        state_s    = RD_TS;
                        addr_s     = 1'b1;
                        tmo_s      = 16'd0;
                    end else begin
                        state_s = LAT_ID;
                        read_s  = 1'b0;
                        lat_s   = 2'd0;
                        tmo_s   = tmo_inc_s;
                    end
                end else begin
                    tmo_s = tmo_inc_s;
                end
            end
            LAT_ID: begin
                in_phase_s = 1'b1;
                lat_s      = lat_inc_s;
                if (lat_inc_s == LAT_LIM) begin
                    capture_s  = 1'b1;
                    id_value_s = avm_readdata;
                    state_s    = RD_TS;
                    read_s     = 1'b1;
                    addr_s     = 1'b1;
                    tmo_s      = 16'd0;
                end else begin
                    tmo_s = tmo_inc_s;
                end
            end
            RD_TS: begin
                in_phase_s = 1'b1;
                if (!avm_waitrequest) begin
                    if (LAT_LIM == 2'd0) begin
                        capture_s  = 1'b1;
                        ts_value_s = avm_readdata;
                        state_s    = FIN;
                        read_s     = 1'b0;
                        addr_s     = 1'b0;
                    end else begin
                        state_s = LAT_TS;
                        read_s  = 1'b0;
                        lat_s   = 2'd0;
                        tmo_s   = tmo_inc_s;
                    end
                end else begin
                    tmo_s = tmo_inc_s;
                end
            end
            LAT_TS: begin
                in_phase_s = 1'b1;
                lat_s      = lat_inc_s;
                if (lat_inc_s == LAT_LIM) begin
                    capture_s  = 1'b1;
                    ts_value_s = avm_readdata;
                    state_s    = FIN;
                    addr_s     = 1'b0;
                end else begin
                    tmo_s = tmo_inc_s;
                end
            end
            FIN: begin
                id_ok_s = (id_value_r == EXPECTED_ID);
                ts_ok_s = (ts_value_r == EXPECTED_TIMESTAMP);
                done_s  = 1'b1;
                busy_s  = 1'b0;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                read_s  = 1'b0;
                addr_s  = 1'b0;
                busy_s  = 1'b0;
            end
        endcase

        // Abort a phase that hits the cycle limit without capturing; a capture
        // on the same cycle wins. The aborted phase's value stays at zero.
        if (in_phase_s && !capture_s && (tmo_inc_s == TMO_LIM)) begin
            state_s   = IDLE;
            read_s    = 1'b0;
            addr_s    = 1'b0;
            timeout_s = 1'b1;
            id_ok_s   = 1'b0;
            ts_ok_s   = 1'b0;
            done_s    = 1'b1;
            busy_s    = 1'b0;
        end else begin
        end
    end

    // State and output registers; reset drops the read strobe immediately
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            first_r    <= 1'b1;
            tmo_r      <= 16'd0;
            lat_r      <= 2'd0;
            read_r     <= 1'b0;
            addr_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            id_ok_r    <= 1'b0;
            ts_ok_r    <= 1'b0;
            timeout_r  <= 1'b0;
            id_value_r <= 32'd0;
            ts_value_r <= 32'd0;
        end else begin
            state_r    <= state_s;
            first_r    <= first_s;
            tmo_r      <= tmo_s;
            lat_r      <= lat_s;
            read_r     <= read_s;
            addr_r     <= addr_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            id_ok_r    <= id_ok_s;
            ts_ok_r    <= ts_ok_s;
            timeout_r  <= timeout_s;
            id_value_r <= id_value_s;
            ts_value_r <= ts_value_s;
        end
    end

    assign avm_read        = read_r;
    assign avm_address     = addr_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign id_ok           = id_ok_r;
    assign timestamp_ok    = ts_ok_r;
    assign timeout         = timeout_r;
    assign id_value        = id_value_r;
    assign timestamp_value = ts_value_r;

endmodule

// File: tb/tb_lcd_display_sysid_checker.sv
// -----------------------------------------------------------------------------
// Testbench for lcd_display_sysid_checker.
//
// Two instances share the clock and reset:
//   instance 0 uses READ_LATENCY = 0;
//   instance 1 uses READ_LATENCY = 2.
// Both use TIMEOUT_CYCLES = 10 and AUTO_START = 1.
//
// Each instance has its own Avalon slave model with configurable behaviour:
//   - stall cycles per read;
//   - a stuck waitrequest (always, or only on the timestamp address);
//   - the ID and timestamp words it returns.
//
// Expected results come from simple rules:
//   - start-to-done = 4 + 2*latency + waitrequest cycles;
//   - the ok flags are equality against the expected constants;
//   - timeout cycle counts follow from the limit.
// -----------------------------------------------------------------------------
module tb_lcd_display_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1430493118;
    localparam int          TMO    = 10;
    localparam logic [31:0] JUNK   = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start_v [2];
    logic        rd      [2];
    logic        ad      [2];
    logic        wr      [2];
    logic [31:0] rdata   [2];
    logic        busy    [2];
    logic        done    [2];
    logic        idok    [2];
    logic        tsok    [2];
    logic        tmo     [2];
    logic [31:0] idv     [2];
    logic [31:0] tsv     [2];

    int          cfg_wait  [2];   // stall cycles before each read is accepted
    int          cfg_stuck [2];   // 0 none, 1 waitrequest always high, 2 high on address 1
    logic [31:0] cfg_id    [2];
    logic [31:0] cfg_ts    [2];

    int passed = 0;
    int total  = 0;

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam int LAT = (g == 0) ? 0 : 2;
        int          stall_cnt = 0;
        logic [31:0] pipe1 = JUNK;
        logic [31:0] pipe2 = JUNK;
        logic [31:0] word_s;

        assign word_s = ad[g] ? cfg_ts[g] : cfg_id[g];
        assign wr[g]  = (cfg_stuck[g] == 1) || ((cfg_stuck[g] == 2) && rd[g] && ad[g]) ||
                        (rd[g] && (stall_cnt < cfg_wait[g]));

        always @(posedge clk) begin
            stall_cnt <= (rd[g] && wr[g]) ? stall_cnt + 1 : 0;
            pipe1     <= (rd[g] && !wr[g]) ? word_s : JUNK;
            pipe2     <= pipe1;
        end

        if (LAT == 0) begin : g_direct
            assign rdata[g] = (rd[g] && !wr[g]) ? word_s : JUNK;
        end else begin : g_delayed
            assign rdata[g] = pipe2;
        end

        lcd_display_sysid_checker #(
            .EXPECTED_ID       (EXP_ID),
            .EXPECTED_TIMESTAMP(EXP_TS),
            .READ_LATENCY      (LAT),
            .TIMEOUT_CYCLES    (TMO),
            .AUTO_START        (1'b1)
        ) dut (
            .clock          (clk),
            .reset          (rst),
            .start          (start_v[g]),
            .avm_address    (ad[g]),
            .avm_read       (rd[g]),
            .avm_waitrequest(wr[g]),
            .avm_readdata   (rdata[g]),
            .busy           (busy[g]),
            .done           (done[g]),
            .id_ok          (idok[g]),
            .timestamp_ok   (tsok[g]),
            .timeout        (tmo[g]),
            .id_value       (idv[g]),
            .timestamp_value(tsv[g])
        );
    end

    function automatic int lat_of(input int g);
        return (g == 0) ? 0 : 2;
    endfunction

    // Watch one instance from the edge that sampled start (or reset release)
    // until done rises; cycles counts negedges, so done seen in cycle N gives N.
    task automatic observe(input int g, output int cycles, output int rd_cycles,
                           output int n_acc, output logic [1:0] acc_addr, output bit stable);
        bit   prev_stall = 1'b0;
        logic prev_addr  = 1'b0;
        cycles    = 0;
        rd_cycles = 0;
        n_acc     = 0;
        acc_addr  = 2'b11;
        stable    = 1'b1;
        while (cycles < 200) begin
            @(negedge clk);
            if (cycles == 0) start_v[g] = 1'b0;
            cycles++;
            if (prev_stall && !(rd[g] === 1'b1 && ad[g] === prev_addr)) stable = 1'b0;
            if (rd[g] === 1'b1) rd_cycles++;
            if (rd[g] === 1'b1 && wr[g] === 1'b0) begin
                if (n_acc < 2) acc_addr[n_acc] = ad[g];
                n_acc++;
            end
            prev_stall = (rd[g] === 1'b1) && (wr[g] === 1'b1);
            prev_addr  = ad[g];
            if (done[g] === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            total++;
            if ({rd[g], ad[g], busy[g], done[g], idok[g], tsok[g], tmo[g], idv[g], tsv[g]} !== 71'd0) begin
                $display("FAIL reset_state[%0d]: got rd=%b ad=%b busy=%b done=%b idok=%b tsok=%b to=%b id=%h ts=%h, want all 0",
                         g, rd[g], ad[g], busy[g], done[g], idok[g], tsok[g], tmo[g], idv[g], tsv[g]);
            end else passed++;
        end
    endtask

    task automatic test_auto_start();
        int cyc [2]; int rc [2]; int na [2]; logic [1:0] aa [2]; bit st [2];
        rst = 1'b0;
        fork
            observe(0, cyc[0], rc[0], na[0], aa[0], st[0]);
            observe(1, cyc[1], rc[1], na[1], aa[1], st[1]);
        join
        for (int g = 0; g < 2; g++) begin
            total++;
            if (cyc[g] !== 4 + 2 * lat_of(g)) begin
                $display("FAIL auto_latency[%0d]: got %0d cycles, want %0d", g, cyc[g], 4 + 2 * lat_of(g));
            end else passed++;
            total++;
            if (na[g] !== 2 || aa[g] !== 2'b10) begin
                $display("FAIL auto_reads[%0d]: got %0d reads order=%b, want 2 reads addr 0 then 1", g, na[g], aa[g]);
            end else passed++;
            total++;
            if ({busy[g], done[g], idok[g], tsok[g], tmo[g]} !== 5'b01110) begin
                $display("FAIL auto_status[%0d]: got busy/done/idok/tsok/to=%b, want 01110", g,
                         {busy[g], done[g], idok[g], tsok[g], tmo[g]});
            end else passed++;
            total++;
            if (tsv[g] !== EXP_TS || idv[g] !== EXP_ID) begin
                $display("FAIL auto_values[%0d]: got id=%0d ts=%0d, want id=%0d ts=%0d", g, idv[g], tsv[g], EXP_ID, EXP_TS);
            end else passed++;
        end
    endtask

    // Fixed corner cases first (stalls, off-by-one timestamp), then random ones
    task automatic test_functional();
        int cyc; int rc; int na; logic [1:0] aa; bit st; int g; int exp_cyc;
        logic [4:0] exp_status;
        for (int it = 0; it < 14; it++) begin
            g = it % 2;
            if (it < 2) begin
                cfg_wait[g] = 3; cfg_id[g] = EXP_ID; cfg_ts[g] = EXP_TS;
            end else if (it < 4) begin
                cfg_wait[g] = it - 2; cfg_id[g] = EXP_ID; cfg_ts[g] = EXP_TS + 32'd1;
            end else begin
                cfg_wait[g] = $urandom_range(3, 0);
                cfg_id[g]   = ($urandom_range(1, 0) == 0) ? EXP_ID : 32'($urandom());
                cfg_ts[g]   = ($urandom_range(1, 0) == 0) ? EXP_TS : 32'($urandom());
            end
            exp_cyc    = 4 + 2 * lat_of(g) + 2 * cfg_wait[g];
            exp_status = {1'b0, 1'b1, cfg_id[g] == EXP_ID, cfg_ts[g] == EXP_TS, 1'b0};
            @(negedge clk);
            start_v[g] = 1'b1;
            observe(g, cyc, rc, na, aa, st);
            total++;
            if (cyc !== exp_cyc) begin
                $display("FAIL run_latency[%0d/%0d]: got %0d cycles, want %0d (wait=%0d)", it, g, cyc, exp_cyc, cfg_wait[g]);
            end else passed++;
            total++;
            if (na !== 2 || aa !== 2'b10 || st !== 1'b1) begin
                $display("FAIL run_protocol[%0d/%0d]: got reads=%0d order=%b stable=%b, want 2 / 10 / 1", it, g, na, aa, st);
            end else passed++;
            total++;
            if ({busy[g], done[g], idok[g], tsok[g], tmo[g]} !== exp_status) begin
                $display("FAIL run_status[%0d/%0d]: got busy/done/idok/tsok/to=%b, want %b", it, g,
                         {busy[g], done[g], idok[g], tsok[g], tmo[g]}, exp_status);
            end else passed++;
            total++;
            if (idv[g] !== cfg_id[g] || tsv[g] !== cfg_ts[g]) begin
                $display("FAIL run_values[%0d/%0d]: got id=%h ts=%h, want id=%h ts=%h", it, g, idv[g], tsv[g], cfg_id[g], cfg_ts[g]);
            end else passed++;
        end
    endtask

    task automatic test_timeout();
        int cyc; int rc; int na; logic [1:0] aa; bit st;
        int exp_cyc; int exp_rc; logic [31:0] exp_id;
        for (int g = 0; g < 2; g++) begin
            for (int mode = 1; mode <= 2; mode++) begin
                cfg_wait[g]  = 0;
                cfg_stuck[g] = mode;
                cfg_id[g]    = 32'h0000_0100 + 32'(g * 4 + mode);
                cfg_ts[g]    = EXP_TS;
                exp_cyc = (mode == 1) ? TMO + 1 : TMO + 2 + lat_of(g);
                exp_rc  = (mode == 1) ? TMO : TMO + 1;
                exp_id  = (mode == 1) ? 32'd0 : cfg_id[g];
                @(negedge clk);
                start_v[g] = 1'b1;
                observe(g, cyc, rc, na, aa, st);
                total++;
                if (cyc !== exp_cyc || rc !== exp_rc) begin
                    $display("FAIL timeout_timing[%0d/%0d]: got done at %0d, read high %0d, want %0d / %0d",
                             g, mode, cyc, rc, exp_cyc, exp_rc);
                end else passed++;
                total++;
                if ({rd[g], busy[g], done[g], idok[g], tsok[g], tmo[g]} !== 6'b001001) begin
                    $display("FAIL timeout_status[%0d/%0d]: got rd/busy/done/idok/tsok/to=%b, want 001001", g, mode,
                             {rd[g], busy[g], done[g], idok[g], tsok[g], tmo[g]});
                end else passed++;
                total++;
                if (idv[g] !== exp_id || tsv[g] !== 32'd0) begin
                    $display("FAIL timeout_values[%0d/%0d]: got id=%h ts=%h, want id=%h ts=0", g, mode, idv[g], tsv[g], exp_id);
                end else passed++;
            end
            // Healthy slave again: the next check passes and clears timeout
            cfg_stuck[g] = 0;
            cfg_id[g]    = EXP_ID;
            @(negedge clk);
            start_v[g] = 1'b1;
            observe(g, cyc, rc, na, aa, st);
            total++;
            if (cyc !== 4 + 2 * lat_of(g) || {busy[g], done[g], idok[g], tsok[g], tmo[g]} !== 5'b01110) begin
                $display("FAIL timeout_recover[%0d]: got %0d cycles status=%b, want %0d cycles status=01110", g, cyc,
                         {busy[g], done[g], idok[g], tsok[g], tmo[g]}, 4 + 2 * lat_of(g));
            end else passed++;
        end
    endtask

    task automatic test_reset_mid();
        int cyc [2]; int rc [2]; int na [2]; logic [1:0] aa [2]; bit st [2];
        bit found = 1'b0;
        for (int g = 0; g < 2; g++) begin
            cfg_id[g] = EXP_ID; cfg_ts[g] = EXP_TS; cfg_stuck[g] = 0;
        end
        cfg_wait[0] = 3;
        cfg_wait[1] = 0;
        @(negedge clk);
        start_v[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start_v[0] = 1'b0;
            if (rd[0] === 1'b1 && ad[0] === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (found !== 1'b1) begin
            $display("FAIL midreset_reach_ts: got no timestamp read within 20 cycles, want one");
        end else passed++;
        rst = 1'b1;
        #1;
        for (int g = 0; g < 2; g++) begin
            total++;
            if ({rd[g], ad[g], busy[g], done[g], idok[g], tsok[g], tmo[g], idv[g], tsv[g]} !== 71'd0) begin
                $display("FAIL midreset_clear[%0d]: got rd=%b busy=%b done=%b idok=%b tsok=%b to=%b id=%h ts=%h, want all 0",
                         g, rd[g], busy[g], done[g], idok[g], tsok[g], tmo[g], idv[g], tsv[g]);
            end else passed++;
        end
        @(negedge clk);
        rst = 1'b0;
        fork
            observe(0, cyc[0], rc[0], na[0], aa[0], st[0]);
            observe(1, cyc[1], rc[1], na[1], aa[1], st[1]);
        join
        for (int g = 0; g < 2; g++) begin
            total++;
            if (cyc[g] !== 4 + 2 * lat_of(g) + 2 * cfg_wait[g] ||
                {busy[g], done[g], idok[g], tsok[g], tmo[g]} !== 5'b01110) begin
                $display("FAIL midreset_rerun[%0d]: got %0d cycles status=%b, want %0d cycles status=01110", g, cyc[g],
                         {busy[g], done[g], idok[g], tsok[g], tmo[g]}, 4 + 2 * lat_of(g) + 2 * cfg_wait[g]);
            end else passed++;
        end
    endtask

    task automatic test_back_to_back();
        int cyc; int rc; int na; logic [1:0] aa; bit st;
        logic busy_seen = 1'b0;
        cfg_wait[1] = 3;
        @(negedge clk);
        start_v[1] = 1'b1;
        fork
            observe(1, cyc, rc, na, aa, st);
            begin
                repeat (3) @(negedge clk);
                busy_seen  = busy[1];
                start_v[1] = 1'b1;
                @(negedge clk);
                start_v[1] = 1'b0;
            end
        join
        total++;
        if (busy_seen !== 1'b1 || cyc !== 4 + 4 + 6) begin
            $display("FAIL busy_start_latency: got busy=%b done at %0d, want busy=1 done at 14", busy_seen, cyc);
        end else passed++;
        repeat (4) @(negedge clk);
        total++;
        if ({rd[1], busy[1], done[1]} !== 3'b001) begin
            $display("FAIL busy_start_ignored: got rd/busy/done=%b, want 001 (no second run)", {rd[1], busy[1], done[1]});
        end else passed++;
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            start_v[g]   = 1'b0;
            cfg_wait[g]  = 0;
            cfg_stuck[g] = 0;
            cfg_id[g]    = EXP_ID;
            cfg_ts[g]    = EXP_TS;
        end
        test_reset();
        test_auto_start();
        test_functional();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", passed, total);
        $fatal(1);
    end

endmodule

// File: doc/lcd_display_sysid_checker.md
# lcd_display_sysid_checker

Avalon-MM read master that sits opposite the system-ID slave on the same control interconnect. After reset, or on a start pulse, it reads the ID word (address 0) and the timestamp word (address 1). It compares both against build-time expected values and reports pass/fail/timeout status, so boot logic can refuse to drive the LCD when the hardware image and software disagree.

## Interface
Parameters:
- EXPECTED_ID, 32'd0: value required at address 0.
- EXPECTED_TIMESTAMP, 32'd1430493118: value required at address 1.
- READ_LATENCY, 0: fixed Avalon read latency in cycles; legal range 0..3.
- TIMEOUT_CYCLES, 255: maximum cycles per read phase before abort; legal range 1..65535.
- AUTO_START, 1: if 1, run one check automatically after reset release.

Ports (all inputs and outputs are synchronous to clock; the only exception is reset):
- clock, in, 1: single clock for the whole block.
- reset, in, 1: asynchronous, active-high reset.
- start, in, 1: one-cycle request to run a check; ignored while busy=1.
- avm_address, out, 1: word address; 0 selects ID, 1 selects timestamp.
- avm_read, out, 1: read strobe.
- avm_waitrequest, in, 1: slave stall.
- avm_readdata, in, 32: read data.
- busy, out, 1: high while a check is running.
- done, out, 1: high from check completion until the next accepted start.
- id_ok, out, 1: captured ID equals EXPECTED_ID.
- timestamp_ok, out, 1: captured timestamp equals EXPECTED_TIMESTAMP.
- timeout, out, 1: the check aborted on a timeout.
- id_value, out, 32: captured ID word.
- timestamp_value, out, 32: captured timestamp word.

## Operation
- FSM states: IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, FIN.
- IDLE:
  - Leave on start=1, or on the first cycle after reset release when AUTO_START=1.
  - On leaving, clear done, id_ok, timestamp_ok and timeout; set busy.
  - Next state is RD_ID.
- RD_ID:
  - Drive avm_read=1 and avm_address=0.
  - Hold address and read while avm_waitrequest=1.
  - The read is accepted on the first cycle with avm_waitrequest=0.
  - If READ_LATENCY=0: capture avm_readdata into id_value in that same cycle, then go to RD_TS.
  - If READ_LATENCY>0: deassert read and go to LAT_ID.
- LAT_ID:
  - avm_read=0.
  - A latency counter runs from 1 to READ_LATENCY.
  - Capture avm_readdata on the cycle the counter reaches READ_LATENCY, then go to RD_TS.
- RD_TS and LAT_TS: identical to RD_ID and LAT_ID, but with avm_address=1 and the capture going into timestamp_value. The next state is FIN.
- FIN (one cycle):
  - id_ok <= (id_value == EXPECTED_ID).
  - timestamp_ok <= (timestamp_value == EXPECTED_TIMESTAMP).
  - done <= 1, busy <= 0.
  - Next state is IDLE.
- Timeout:
  - A 16-bit counter clears on entry to RD_ID and again on entry to RD_TS.
  - It increments on every cycle spent in RD_x or LAT_x.
  - If it reaches TIMEOUT_CYCLES before the capture:
    - drop avm_read immediately;
    - set timeout=1, id_ok=0, timestamp_ok=0, done=1, busy=0;
    - go to IDLE.
  - Captured values from the completed phase are kept; the value for the aborted phase is left at 0.
- Start is sampled only in IDLE. A start that coincides with reset release is ignored; with AUTO_START=1 the automatic run happens anyway.
- Comparisons are full 32-bit equality. There is no masking.

## Timing
- Reset values: avm_read=0, avm_address=0, busy=0, done=0, id_ok=0, timestamp_ok=0, timeout=0, id_value=0, timestamp_value=0. The FSM returns to IDLE.
- Reset asserted mid-read: avm_read drops asynchronously in the same cycle, and all status is lost. With AUTO_START=1 the check reruns after reset release.
- avm_read, avm_address, busy and the status outputs are all registered.
- Best case (READ_LATENCY=0, no wait):
  - start sampled at cycle 0;
  - cycle 1: RD_ID (read, address 0);
  - cycle 2: RD_TS (read, address 1);
  - cycle 3: FIN;
  - done=1 and the ok flags are visible from cycle 4.
- General latency, start to done: 4 + 2*READ_LATENCY + (total waitrequest cycles).
- There is never more than one outstanding read. avm_read is low for at least one cycle between the two reads only when READ_LATENCY>0.

## Test plan
- Slave model returns address ? 1430493118 : 0, waitrequest=0, latency 0, AUTO_START=1. Release reset -> address 0 then address 1 read on consecutive cycles; done=1 on the 4th cycle after release; id_ok=1, timestamp_ok=1, timestamp_value=1430493118.
- Same model, but waitrequest held high for 3 cycles on each read -> address and read remain stable while stalled; done 6 cycles later than the baseline; both ok flags=1.
- READ_LATENCY=2, slave presents data 2 cycles after acceptance -> correct capture; done at cycle 8 after start.
- Slave returns timestamp 1430493119 -> id_ok=1, timestamp_ok=0, timeout=0, done=1.
- waitrequest stuck at 1, TIMEOUT_CYCLES=10 -> avm_read drops after 10 cycles; timeout=1, done=1, both ok flags=0, busy=0. A later start with a healthy slave passes and clears timeout.
- Reset pulsed during RD_TS -> all outputs return to 0 immediately, and a fresh check completes with a pass. A start pulse while busy=1 has no effect.
